customized_round_to_single: RTL



---
 rtl/customized_round_to_single.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/customized_round_to_single.sv
// customized_round_to_single
// Two-stage rounding pipeline: converts the wide-mantissa multiplier product
// {sign, exp[7:0], mantissa[montissa_len_in-1:0]} to IEEE-754 single precision
// with round-to-nearest-even. Stage 1 splits the mantissa into kept/guard/sticky
// fields and decides the rounding increment; stage 2 applies the increment,
// resolves special cases and holds the result under backpressure.
module customized_round_to_single #(
    parameter int montissa_len_in = 47,
    parameter int CNT_W           = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [montissa_len_in+8:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic                       out_inexact,
    output logic                       out_overflow,
    output logic [CNT_W-1:0]           inexact_cnt,
    input  logic                       cnt_clr
);

    localparam int M = montissa_len_in;

    // Round-to-nearest-even increment: round up above half, or on an exact tie
    // when the kept LSB is odd.
    function automatic logic rne_up(input logic guard, input logic sticky, input logic lsb);
        return guard & (sticky | lsb);
    endfunction

    // ------------------------------------------------------------------
    // Input field extraction
    // ------------------------------------------------------------------
    logic          in_sign_s;
    logic [7:0]    in_exp_s;
    logic [M-1:0]  in_man_s;
    logic [22:0]   in_t_s;
    logic          in_g_s;
    logic          in_sticky_s;

    assign in_sign_s = in_data[M+8];
    assign in_exp_s  = in_data[M+7:M];
    assign in_man_s  = in_data[M-1:0];
    assign in_t_s    = in_man_s[M-1:M-23];
    assign in_g_s    = in_man_s[M-24];

    // With a 24-bit mantissa there are no bits below the guard bit.
    generate
        if (M > 24) begin : g_sticky
            assign in_sticky_s = |in_man_s[M-25:0];
        end else begin : g_no_sticky
            assign in_sticky_s = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_load_s;
    logic s1_adv_s;

    assign s2_load_s = ~s2_valid_q | out_ready;
    assign s1_adv_s  = ~s1_valid_q | s2_load_s;
    // Held low while reset is asserted so no word is offered into a clearing pipe.
    assign in_ready  = ~rst & s1_adv_s;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic        s1_sign_q, s1_sign_d;
    logic [7:0]  s1_exp_q,  s1_exp_d;
    logic [22:0] s1_t_q,    s1_t_d;
    logic        s1_g_q,    s1_g_d;
    logic        s1_s_q,    s1_s_d;
    logic        s1_zero_q, s1_zero_d;
    logic        s1_inf_q,  s1_inf_d;
    logic        s1_rnd_q,  s1_rnd_d;

    // Stage 1 next state: capture the split fields on an input handshake.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_t_d     = s1_t_q;
        s1_g_d     = s1_g_q;
        s1_s_d     = s1_s_q;
        s1_zero_d  = s1_zero_q;
        s1_inf_d   = s1_inf_q;
        s1_rnd_d   = s1_rnd_q;
        if (s1_adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign_s;
                s1_exp_d  = in_exp_s;
                s1_t_d    = in_t_s;
                s1_g_d    = in_g_s;
                s1_s_d    = in_sticky_s;
                s1_zero_d = (in_exp_s == 8'd0);
                s1_inf_d  = (in_exp_s == 8'hFF);
                s1_rnd_d  = rne_up(in_g_s, in_sticky_s, in_t_s[0]);
            end else begin
                s1_sign_d = s1_sign_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: apply rounding and special cases
    // ------------------------------------------------------------------
    logic [23:0] sum_s;
    logic        carry_s;
    logic [22:0] man_s;
    logic [7:0]  exp_inc_s;
    logic        nz_s;
    logic [22:0] nan_man_s;
    logic [31:0] res_data_s;
    logic        res_inexact_s;
    logic        res_overflow_s;

    assign sum_s     = {1'b0, s1_t_q} + {23'd0, s1_rnd_q};
    assign carry_s   = sum_s[23];
    assign man_s     = carry_s ? 23'd0 : sum_s[22:0];
    // Only reached with exp <= 254, so the increment cannot wrap.
    assign exp_inc_s = s1_exp_q + {7'd0, carry_s};
    assign nz_s      = (|s1_t_q) | s1_g_q | s1_s_q;
    // A NaN whose payload lives entirely below the kept bits must stay a NaN.
    assign nan_man_s = ((s1_t_q == 23'd0) && nz_s) ? 23'h400000 : s1_t_q;

    // Result selection in priority order: zero/flush, inf/NaN, overflow, normal.
    always_comb begin
        res_data_s     = 32'd0;
        res_inexact_s  = 1'b0;
        res_overflow_s = 1'b0;
        if (s1_zero_q) begin
            res_data_s    = {s1_sign_q, 31'd0};
            res_inexact_s = nz_s;
        end else if (s1_inf_q) begin
            res_data_s = {s1_sign_q, 8'hFF, nan_man_s};
        end else if (exp_inc_s == 8'hFF) begin
            res_data_s     = {s1_sign_q, 8'hFF, 23'd0};
            res_inexact_s  = 1'b1;
            res_overflow_s = 1'b1;
        end else begin
            res_data_s    = {s1_sign_q, exp_inc_s, man_s};
            res_inexact_s = s1_g_q | s1_s_q;
        end
    end

    logic [31:0] out_data_q,     out_data_d;
    logic        out_inexact_q,  out_inexact_d;
    logic        out_overflow_q, out_overflow_d;

    // Stage 2 next state: load from stage 1 when empty or being drained, else hold.
    always_comb begin
        s2_valid_d     = s2_valid_q;
        out_data_d     = out_data_q;
        out_inexact_d  = out_inexact_q;
        out_overflow_d = out_overflow_q;
        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d     = res_data_s;
                out_inexact_d  = res_inexact_s;
                out_overflow_d = res_overflow_s;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // ------------------------------------------------------------------
    // Inexact counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] inexact_cnt_q, inexact_cnt_d;

    // Saturating count of delivered inexact results; clear wins over a handshake.
    always_comb begin
        inexact_cnt_d = inexact_cnt_q;
        if (cnt_clr) begin
            inexact_cnt_d = {CNT_W{1'b0}};
        end else if (s2_valid_q && out_ready && out_inexact_q &&
                     (inexact_cnt_q != {CNT_W{1'b1}})) begin
            inexact_cnt_d = inexact_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            inexact_cnt_d = inexact_cnt_q;
        end
    end

    // Pipeline and counter registers; reset discards any in-flight words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_exp_q       <= 8'd0;
            s1_t_q         <= 23'd0;
            s1_g_q         <= 1'b0;
            s1_s_q         <= 1'b0;
            s1_zero_q      <= 1'b0;
            s1_inf_q       <= 1'b0;
            s1_rnd_q       <= 1'b0;
            s2_valid_q     <= 1'b0;
            out_data_q     <= 32'd0;
            out_inexact_q  <= 1'b0;
            out_overflow_q <= 1'b0;
            inexact_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_sign_q      <= s1_sign_d;
            s1_exp_q       <= s1_exp_d;
            s1_t_q         <= s1_t_d;
            s1_g_q         <= s1_g_d;
            s1_s_q         <= s1_s_d;
            s1_zero_q      <= s1_zero_d;
            s1_inf_q       <= s1_inf_d;
            s1_rnd_q       <= s1_rnd_d;
            s2_valid_q     <= s2_valid_d;
            out_data_q     <= out_data_d;
            out_inexact_q  <= out_inexact_d;
            out_overflow_q <= out_overflow_d;
            inexact_cnt_q  <= inexact_cnt_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = out_data_q;
    assign out_inexact  = out_inexact_q;
    assign out_overflow = out_overflow_q;
    assign inexact_cnt  = inexact_cnt_q;

endmodule
